sc_levelup_ctrl: RTL and testbench
==================================

// Module: sc_levelup_ctrl
// PURPOSE
//  Upstream stage of the level counter: turns game "point scored" events into level-up requests.
//  Counts rising edges of a point strobe and, every POINTS_PER_LEVEL points, issues a one-cycle
//  upLEVEL pulse to the level counter. It then runs a cooldown (flash) window.
//  Stops requesting once the current level reaches MAX_LEVEL, so the 2-bit level counter never wraps.
// PARAMETERS
//  POINTS_PER_LEVEL  4  points needed per level-up (>=2)
//  POINTCOUNT_WIDTH  3  width of point counter; must hold POINTS_PER_LEVEL-1
//  LEVEL_WIDTH       2  width of level feedback bus (matches level counter)
//  MAX_LEVEL         3  level at which further requests are suppressed
//  COOLDOWN_CYCLES   8  length of post-level-up flash window, in clocks (>=1)
//  COOLDOWN_WIDTH    4  width of cooldown counter; must hold COOLDOWN_CYCLES-1
// PORTS
//  SC_LEVELUPCTRL_CLOCK_50       in   1  system clock (single clock domain)
//  SC_LEVELUPCTRL_RESET_InHigh   in   1  synchronous active-high reset
//  SC_LEVELUPCTRL_clear_InHigh   in   1  synchronous new-game clear, same effect as reset
//  SC_LEVELUPCTRL_point_In       in   1  point strobe, already synchronous; only rising edges count
//  SC_LEVELUPCTRL_level_InBUS    in   LEVEL_WIDTH  current level fed back from level counter
//  SC_LEVELUPCTRL_upLEVEL_Out    out  1  one-cycle level-up pulse to level counter
//  SC_LEVELUPCTRL_points_OutBUS  out  POINTCOUNT_WIDTH  points accumulated toward next level
//  SC_LEVELUPCTRL_flash_Out      out  1  high during cooldown window
//  SC_LEVELUPCTRL_maxLevel_Out   out  1  high while in MAXED state
// BEHAVIOUR
//  - Reset/clear: state=COUNT, points=0, cooldown=0, point_prev=0; all outputs 0. Takes effect on the next edge.
//    Reset has priority over clear; clear has priority over everything else, including a simultaneous rise.
//  - rise = point_In & ~point_prev; point_prev is registered every cycle in all states, so a held-high strobe counts once.
//  - FSM (Moore outputs). Transitions are evaluated at the edge that samples rise.
//    COUNT:    on rise, if points < POINTS_PER_LEVEL-1: points+1.
//              On rise with points == POINTS_PER_LEVEL-1: points<=0.
//                If level_InBUS < MAX_LEVEL, go to LEVELUP; otherwise go to MAXED.
//    LEVELUP:  upLEVEL_Out=1 for exactly this one cycle.
//              Go to COOLDOWN and load cooldown <= COOLDOWN_CYCLES-1.
//    COOLDOWN: flash_Out=1; rises are dropped (not counted).
//              If cooldown==0, go to COUNT; else decrement.
//    MAXED:    maxLevel_Out=1; rises increment points, saturating at POINTS_PER_LEVEL-1; no upLEVEL ever.
//              Exit only by reset/clear.
//  - Latency: rise sampled at edge N -> upLEVEL_Out high in cycle N..N+1 -> level counter increments at edge N+1.
//  - flash_Out is high for exactly COOLDOWN_CYCLES cycles.
//  - level_InBUS is stable in COUNT (it only changes after LEVELUP), so it is sampled combinationally; no extra register.
//  - Arithmetic is unsigned. The points counter never exceeds POINTS_PER_LEVEL-1 and never wraps.
//  - Unused state encodings recover to COUNT on the next edge.
// STRUCTURE
//  - Include file sc_levelup_defs.vh holds the FSM state localparams (COUNT=2'd0, LEVELUP=2'd1, COOLDOWN=2'd2, MAXED=2'd3).
//    The level counter width constant lives in the same file so both stages share it.
//  - Sub-module sc_rise_detect (clock, sync reset, in, out rise) holds point_prev.
//    Its reset input is (reset | clear).
//  - Three processes: combinational next-state/next-data, sequential registers, combinational outputs.
// TESTING
//  1. Reset, then 4 single-cycle point pulses at level 0 -> points 1,2,3,0.
//     upLEVEL high exactly 1 cycle, at the cycle after the 4th rise; flash high 8 cycles after it.
//  2. point_In held high 20 cycles in COUNT -> points increments once only; no upLEVEL.
//  3. Point pulses during flash window -> ignored; points stays 0.
//     First pulse after flash drops -> points=1.
//  4. level_InBUS=3, 4 point pulses -> no upLEVEL; maxLevel_Out=1; 5 more pulses -> points saturates at 3.
//  5. Reset asserted mid-cooldown (cycle 3 of 8) -> next cycle flash=0, points=0, state COUNT.
//     Clear together with the 4th rise -> no upLEVEL, points=0.
//  6. Chained with the level counter: 12 pulses from reset -> level 0->1->2->3, then maxLevel_Out=1; level stays 3.

Source files
------------

// File: rtl/sc_levelup_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sc_levelup_ctrl_pkg
//   Shared definitions for the level-up request stage and the level counter.
//   Holds the FSM state encoding and the level bus width so both stages agree.
// ----------------------------------------------------------------------------
package sc_levelup_ctrl_pkg;

  // Width of the level counter bus shared by the level-up stage and the counter.
  localparam int SC_LEVEL_WIDTH = 2;

  typedef enum logic [1:0] {
    ST_COUNT    = 2'd0,
    ST_LEVELUP  = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_MAXED    = 2'd3
  } state_t;

endpackage

// File: rtl/sc_rise_detect.sv
// ----------------------------------------------------------------------------
// sc_rise_detect
//   Rising-edge detector for an already-synchronous strobe.
//   Ports:
//     i_clk   in  1  clock
//     i_rst   in  1  synchronous active-high reset (clears the history bit)
//     i_in    in  1  strobe input
//     o_rise  out 1  high for the cycle in which i_in is high and was low before
// ----------------------------------------------------------------------------
module sc_rise_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_prev <= 1'b0;
    else       r_prev <= i_in;
  end

  assign o_rise = i_in & ~r_prev;

endmodule

// File: rtl/sc_levelup_ctrl.sv
// ----------------------------------------------------------------------------
// sc_levelup_ctrl
//   Turns point-scored strobes into one-cycle level-up requests for the level
//   counter. Every POINTS_PER_LEVEL rising edges of the point strobe a request
//   is issued, followed by a COOLDOWN_CYCLES flash window during which points
//   are ignored. Once the fed-back level has reached MAX_LEVEL, requests stop
//   and the block parks in MAXED until reset/clear.
//   Ports:
//     SC_LEVELUPCTRL_CLOCK_50       in   1      clock
//     SC_LEVELUPCTRL_RESET_InHigh   in   1      synchronous active-high reset
//     SC_LEVELUPCTRL_clear_InHigh   in   1      synchronous new-game clear
//     SC_LEVELUPCTRL_point_In       in   1      point strobe (rising edges count)
//     SC_LEVELUPCTRL_level_InBUS    in   LW     current level from level counter
//     SC_LEVELUPCTRL_upLEVEL_Out    out  1      one-cycle level-up pulse
//     SC_LEVELUPCTRL_points_OutBUS  out  PW     points toward next level
//     SC_LEVELUPCTRL_flash_Out      out  1      high during cooldown window
//     SC_LEVELUPCTRL_maxLevel_Out   out  1      high while maxed out
// ----------------------------------------------------------------------------
module sc_levelup_ctrl
  import sc_levelup_ctrl_pkg::*;
#(
  parameter int POINTS_PER_LEVEL = 4,
  parameter int POINTCOUNT_WIDTH = 3,
  parameter int LEVEL_WIDTH      = SC_LEVEL_WIDTH,
  parameter int MAX_LEVEL        = 3,
  parameter int COOLDOWN_CYCLES  = 8,
  parameter int COOLDOWN_WIDTH   = 4
) (
  input  logic                        SC_LEVELUPCTRL_CLOCK_50,
  input  logic                        SC_LEVELUPCTRL_RESET_InHigh,
  input  logic                        SC_LEVELUPCTRL_clear_InHigh,
  input  logic                        SC_LEVELUPCTRL_point_In,
  input  logic [LEVEL_WIDTH-1:0]      SC_LEVELUPCTRL_level_InBUS,
  output logic                        SC_LEVELUPCTRL_upLEVEL_Out,
  output logic [POINTCOUNT_WIDTH-1:0] SC_LEVELUPCTRL_points_OutBUS,
  output logic                        SC_LEVELUPCTRL_flash_Out,
  output logic                        SC_LEVELUPCTRL_maxLevel_Out
);

  localparam logic [POINTCOUNT_WIDTH-1:0] PTS_TOP   = POINTCOUNT_WIDTH'(POINTS_PER_LEVEL - 1);
  localparam logic [COOLDOWN_WIDTH-1:0]   CD_LOAD   = COOLDOWN_WIDTH'(COOLDOWN_CYCLES - 1);
  localparam logic [LEVEL_WIDTH-1:0]      LEVEL_TOP = LEVEL_WIDTH'(MAX_LEVEL);

  state_t                      r_state,  w_state_nxt;
  logic [POINTCOUNT_WIDTH-1:0] r_points, w_points_nxt;
  logic [COOLDOWN_WIDTH-1:0]   r_cool,   w_cool_nxt;
  logic                        w_rise;
  logic                        w_sync_rst;

  // Reset and clear are equivalent, including for the edge history bit.
  assign w_sync_rst = SC_LEVELUPCTRL_RESET_InHigh | SC_LEVELUPCTRL_clear_InHigh;

  sc_rise_detect u_rise (
    .i_clk  (SC_LEVELUPCTRL_CLOCK_50),
    .i_rst  (w_sync_rst),
    .i_in   (SC_LEVELUPCTRL_point_In),
    .o_rise (w_rise)
  );

  // Next-state / next-data. The level bus is only consulted in COUNT, where it
  // is stable, so it is used directly without a capture register.
  always_comb begin
    w_state_nxt  = r_state;
    w_points_nxt = r_points;
    w_cool_nxt   = r_cool;
    case (r_state)
      ST_COUNT: begin
        if (w_rise) begin
          if (r_points < PTS_TOP) begin
            w_points_nxt = r_points + 1'b1;
          end else begin
            w_points_nxt = '0;
            w_state_nxt  = (SC_LEVELUPCTRL_level_InBUS < LEVEL_TOP) ? ST_LEVELUP : ST_MAXED;
          end
        end
      end
      ST_LEVELUP: begin
        w_state_nxt = ST_COOLDOWN;
        w_cool_nxt  = CD_LOAD;
      end
      ST_COOLDOWN: begin
        // Rises are dropped here; the edge history still tracks the strobe.
        if (r_cool == '0) w_state_nxt = ST_COUNT;
        else              w_cool_nxt  = r_cool - 1'b1;
      end
      ST_MAXED: begin
        // Keep showing progress, but saturate instead of wrapping.
        if (w_rise && (r_points < PTS_TOP)) w_points_nxt = r_points + 1'b1;
      end
      default: w_state_nxt = ST_COUNT;
    endcase
  end

  always_ff @(posedge SC_LEVELUPCTRL_CLOCK_50) begin
    if (w_sync_rst) begin
      r_state  <= ST_COUNT;
      r_points <= '0;
      r_cool   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_points <= w_points_nxt;
      r_cool   <= w_cool_nxt;
    end
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    SC_LEVELUPCTRL_upLEVEL_Out   = (r_state == ST_LEVELUP);
    SC_LEVELUPCTRL_flash_Out     = (r_state == ST_COOLDOWN);
    SC_LEVELUPCTRL_maxLevel_Out  = (r_state == ST_MAXED);
    SC_LEVELUPCTRL_points_OutBUS = r_points;
  end

endmodule

// File: tb/tb_sc_levelup_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sc_levelup_ctrl
//   Directed bench for sc_levelup_ctrl with a small level counter model
//   closing the level feedback loop.
// ----------------------------------------------------------------------------
module tb_sc_levelup_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       pt  = 1'b0;
  logic [1:0] lvl;
  logic       lvl_load = 1'b1;
  logic [1:0] lvl_val  = 2'd0;
  logic       up;
  logic [2:0] points;
  logic       flash;
  logic       maxl;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Level counter model: increments on each level-up pulse.
  always @(posedge clk) begin
    if (lvl_load) lvl <= lvl_val;
    else if (up)  lvl <= lvl + 2'd1;
  end

  sc_levelup_ctrl dut (
    .SC_LEVELUPCTRL_CLOCK_50      (clk),
    .SC_LEVELUPCTRL_RESET_InHigh  (rst),
    .SC_LEVELUPCTRL_clear_InHigh  (clr),
    .SC_LEVELUPCTRL_point_In      (pt),
    .SC_LEVELUPCTRL_level_InBUS   (lvl),
    .SC_LEVELUPCTRL_upLEVEL_Out   (up),
    .SC_LEVELUPCTRL_points_OutBUS (points),
    .SC_LEVELUPCTRL_flash_Out     (flash),
    .SC_LEVELUPCTRL_maxLevel_Out  (maxl)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] start_lvl);
    rst = 1'b1; lvl_val = start_lvl; lvl_load = 1'b1;
    tick(); tick();
    rst = 1'b0; lvl_load = 1'b0;
  endtask

  task automatic pulse();
    pt = 1'b1; tick();
    pt = 1'b0; tick();
  endtask

  task automatic wait_flash_low();
    for (int k = 0; k < 40 && flash; k++) tick();
    if (flash) check_eq("flash_timeout", int'(flash), 0);
  endtask

  int up_seen;
  int flash_n;

  initial begin
    // ---------------- Test 1: basic level-up and flash window
    do_reset(2'd0);
    check_eq("rst_points", int'(points), 0);
    check_eq("rst_up",     int'(up),     0);
    check_eq("rst_flash",  int'(flash),  0);
    check_eq("rst_max",    int'(maxl),   0);
    for (int i = 1; i <= 4; i++) begin
      pt = 1'b1; tick();
      check_eq("t1_points", int'(points), (i == 4) ? 0 : i);
      check_eq("t1_up",     int'(up),     (i == 4) ? 1 : 0);
      pt = 1'b0; tick();
    end
    check_eq("t1_up_after", int'(up),    0);
    check_eq("t1_flash_on", int'(flash), 1);
    check_eq("t1_lvl",      int'(lvl),   1);
    flash_n = 1; up_seen = 0;
    for (int k = 0; k < 20 && flash; k++) begin
      tick();
      if (flash) flash_n++;
      if (up)    up_seen++;
    end
    check_eq("t1_flash_len", flash_n, 8);
    check_eq("t1_up_in_cd",  up_seen, 0);

    // ---------------- Test 2: held-high strobe counts once
    up_seen = 0;
    pt = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (up) up_seen++;
    end
    pt = 1'b0; tick();
    check_eq("t2_points", int'(points), 1);
    check_eq("t2_up",     up_seen,      0);

    // ---------------- Test 3: points during flash are dropped
    pulse(); pulse();
    pt = 1'b1; tick();
    check_eq("t3_up", int'(up), 1);
    pt = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin
      pulse();
      check_eq("t3_cd_points", int'(points), 0);
      check_eq("t3_cd_flash",  int'(flash),  1);
    end
    wait_flash_low();
    pulse();
    check_eq("t3_after_points", int'(points), 1);
    check_eq("t3_lvl",          int'(lvl),    2);

    // ---------------- Test 4: maxed level suppresses requests, points saturate
    do_reset(2'd3);
    up_seen = 0;
    for (int i = 0; i < 4; i++) begin
      pt = 1'b1; tick();
      if (up) up_seen++;
      pt = 1'b0; tick();
      if (up) up_seen++;
    end
    check_eq("t4_max",    int'(maxl),   1);
    check_eq("t4_points", int'(points), 0);
    for (int i = 1; i <= 5; i++) begin
      pt = 1'b1; tick();
      if (up) up_seen++;
      pt = 1'b0; tick();
      if (up) up_seen++;
      check_eq("t4_sat_points", int'(points), (i < 3) ? i : 3);
    end
    check_eq("t4_up",    up_seen,    0);
    check_eq("t4_flash", int'(flash), 0);

    // ---------------- Test 5: reset mid-cooldown, clear with 4th rise
    do_reset(2'd0);
    pulse(); pulse(); pulse(); pulse();
    tick(); tick();
    check_eq("t5_flash_pre", int'(flash), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("t5_flash", int'(flash),  0);
    check_eq("t5_points", int'(points), 0);
    check_eq("t5_up",    int'(up),     0);
    check_eq("t5_max",   int'(maxl),   0);
    pulse(); pulse(); pulse();
    check_eq("t5_points3", int'(points), 3);
    pt = 1'b1; clr = 1'b1; tick();
    clr = 1'b0; pt = 1'b0;
    check_eq("t5_clr_up",     int'(up),     0);
    check_eq("t5_clr_points", int'(points), 0);
    tick();
    check_eq("t5_clr_up2",   int'(up),    0);
    check_eq("t5_clr_flash", int'(flash), 0);

    // ---------------- Test 6: chained with the level counter model
    do_reset(2'd0);
    for (int i = 0; i < 12; i++) begin
      wait_flash_low();
      pulse();
    end
    wait_flash_low();
    check_eq("t6_lvl3",   int'(lvl),  3);
    check_eq("t6_max_no", int'(maxl), 0);
    up_seen = 0;
    for (int i = 0; i < 4; i++) begin
      pt = 1'b1; tick();
      if (up) up_seen++;
      pt = 1'b0; tick();
      if (up) up_seen++;
    end
    check_eq("t6_max",    int'(maxl), 1);
    check_eq("t6_up",     up_seen,    0);
    check_eq("t6_lvl_hold", int'(lvl), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
